// File: rtl/counter_sequencer.sv
// Up/down counter controller: runs the internal WIDTH-bit counter from its current value
// to a captured target, one step every STEP_DIV enabled cycles.
module counter_sequencer #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             ready,
    input  logic             dir,
    input  logic [WIDTH-1:0] target,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int unsigned      PW       = 8;
    localparam logic [PW-1:0]    PSC_LAST = PW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] OUT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    psc, psc_n;
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] out_n;
    logic             ready_n, busy_n, done_n, wrap_n;

    logic             accept, advance, step;
    logic [WIDTH-1:0] stepped;

    // Command acceptance and step qualification; abort blocks both.
    always_comb begin
        accept  = (state == S_IDLE || state == S_DONE) && start && !abort;
        advance = (state == S_RUN || state == S_PAUSE) && !abort && !hold;
        step    = advance && (psc == PSC_LAST);
        stepped = dir_q ? out + WIDTH'(1) : out - WIDTH'(1);
    end

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            psc   <= '0;
            dir_q <= 1'b0;
            tgt_q <= '0;
            out   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            psc   <= psc_n;
            dir_q <= dir_n;
            tgt_q <= tgt_n;
            out   <= out_n;
            ready <= ready_n;
            busy  <= busy_n;
            done  <= done_n;
            wrap  <= wrap_n;
        end
    end

    // Next-state logic; PAUSE resumes on the same edge hold drops, so only held cycles are lost.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) state_n = (target == out) ? S_DONE : S_RUN;
                else        state_n = S_IDLE;
            end
            S_RUN, S_PAUSE: begin
                if (abort)                         state_n = S_IDLE;
                else if (hold)                     state_n = S_PAUSE;
                else if (step && stepped == tgt_q) state_n = S_DONE;
                else                               state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of datapath and outputs.
    always_comb begin
        psc_n  = psc;
        dir_n  = dir_q;
        tgt_n  = tgt_q;
        out_n  = out;
        done_n = 1'b0;
        wrap_n = 1'b0;

        if (accept) begin
            dir_n  = dir;
            tgt_n  = target;
            psc_n  = '0;
            done_n = (target == out);
        end

        if (advance) begin
            psc_n = step ? '0 : psc + PW'(1);
            if (step) begin
                out_n  = stepped;
                wrap_n = dir_q ? (out == OUT_MAX) : (out == '0);
                done_n = (stepped == tgt_q);
            end
        end

        ready_n = (state_n == S_IDLE) || (state_n == S_DONE);
        busy_n  = !ready_n;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (STEP_DIV=1 and 4) checked every cycle
// against a count-by-arithmetic model, plus hand-computed checkpoints.
module tb_counter_sequencer;

    localparam int unsigned W = 3;
    localparam int          M = 8;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         start [2];
    logic         dir   [2];
    logic         hold  [2];
    logic         abort [2];
    logic [W-1:0] target[2];
    logic         ready [2];
    logic         busy  [2];
    logic         done  [2];
    logic         wrap  [2];
    logic [W-1:0] out   [2];

    int n_chk  = 0;
    int n_pass = 0;

    int m_val [2];
    int m_tick[2];
    int m_goal[2];
    bit m_act [2];
    bit m_up  [2];
    bit m_done[2];
    bit m_wrap[2];

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(W), .STEP_DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start[0]), .ready(ready[0]), .dir(dir[0]),
        .target(target[0]), .hold(hold[0]), .abort(abort[0]), .out(out[0]),
        .busy(busy[0]), .done(done[0]), .wrap(wrap[0])
    );

    counter_sequencer #(.WIDTH(W), .STEP_DIV(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start[1]), .ready(ready[1]), .dir(dir[1]),
        .target(target[1]), .hold(hold[1]), .abort(abort[1]), .out(out[1]),
        .busy(busy[1]), .done(done[1]), .wrap(wrap[1])
    );

    function automatic int sd(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    // Model: a command is active until the value lands on the goal; every sd enabled cycles moves it by one.
    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_val[i] = 0; m_tick[i] = 0; m_goal[i] = 0;
                m_act[i] = 0; m_up[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
            end else begin
                m_done[i] = 0;
                m_wrap[i] = 0;
                if (m_act[i]) begin
                    if (abort[i]) m_act[i] = 0;
                    else if (!hold[i]) begin
                        m_tick[i]++;
                        if (m_tick[i] == sd(i)) begin
                            m_tick[i] = 0;
                            m_wrap[i] = m_up[i] ? (m_val[i] == M - 1) : (m_val[i] == 0);
                            m_val[i]  = m_up[i] ? (m_val[i] + 1) % M : (m_val[i] + M - 1) % M;
                            if (m_val[i] == m_goal[i]) begin
                                m_act[i]  = 0;
                                m_done[i] = 1;
                            end
                        end
                    end
                end else if (start[i] && !abort[i]) begin
                    m_up[i]   = dir[i];
                    m_goal[i] = int'(target[i]);
                    m_tick[i] = 0;
                    if (m_goal[i] == m_val[i]) m_done[i] = 1;
                    else                       m_act[i]  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out%0d", i),   int'(out[i]),   m_val[i]);
            chk($sformatf("ready%0d", i), int'(ready[i]), int'(!m_act[i]));
            chk($sformatf("busy%0d", i),  int'(busy[i]),  int'(m_act[i]));
            chk($sformatf("done%0d", i),  int'(done[i]),  int'(m_done[i]));
            chk($sformatf("wrap%0d", i),  int'(wrap[i]),  int'(m_wrap[i]));
        end
    end

    task automatic issue(input int i, input bit d, input logic [W-1:0] t);
        @(negedge clk);
        start[i]  = 1'b1;
        dir[i]    = d;
        target[i] = t;
        @(negedge clk);
        start[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int cyc, output int wraps);
        cyc   = budget;
        wraps = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (wrap[i]) wraps++;
            if (done[i]) begin
                cyc = c;
                return;
            end
        end
        chk("done_timeout", int'(done[i]), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end by %0t", $time);
        $fatal(1);
    end

    initial begin
        int k, w;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; dir[i] = 1'b0; hold[i] = 1'b0; abort[i] = 1'b0; target[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_out", int'(out[0]), 0);
        chk("rst_ready", int'(ready[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        rstn = 1'b1;

        // Up count 0 -> 5
        issue(0, 1'b1, 3'd5);
        wait_done(0, 40, k, w);
        chk("t1_cycles", k, 5);
        chk("t1_out", int'(out[0]), 5);
        @(negedge clk);
        chk("t1_ready_after", int'(ready[0]), 1);

        // Down to 2, then down through zero to 6
        issue(0, 1'b0, 3'd2);
        wait_done(0, 40, k, w);
        chk("t2a_cycles", k, 3);
        chk("t2a_out", int'(out[0]), 2);
        issue(0, 1'b0, 3'd6);
        wait_done(0, 40, k, w);
        chk("t2_cycles", k, 4);
        chk("t2_wraps", w, 1);
        chk("t2_out", int'(out[0]), 6);

        // Up 6 -> 0 via wrap, then abort / start-while-busy
        issue(0, 1'b1, 3'd0);
        wait_done(0, 40, k, w);
        chk("t4_pre_out", int'(out[0]), 0);
        issue(0, 1'b1, 3'd7);
        @(negedge clk);
        @(negedge clk);
        chk("t4_out2", int'(out[0]), 2);
        start[0] = 1'b1; dir[0] = 1'b0; target[0] = 3'd3;
        @(negedge clk);
        start[0] = 1'b0;
        chk("t4_ignored_start", int'(out[0]), 3);
        chk("t4_busy", int'(busy[0]), 1);
        @(negedge clk);
        chk("t4_out4", int'(out[0]), 4);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t4_abort_out", int'(out[0]), 4);
        chk("t4_abort_busy", int'(busy[0]), 0);
        chk("t4_abort_ready", int'(ready[0]), 1);
        repeat (3) @(negedge clk);
        chk("t4_held_out", int'(out[0]), 4);

        // Zero-length command at 3
        issue(0, 1'b0, 3'd3);
        wait_done(0, 40, k, w);
        chk("t5a_cycles", k, 1);
        issue(0, 1'b1, 3'd3);
        chk("t5_done", int'(done[0]), 1);
        chk("t5_out", int'(out[0]), 3);
        chk("t5_wrap", int'(wrap[0]), 0);
        @(negedge clk);
        chk("t5_done_once", int'(done[0]), 0);

        // Abort together with start in IDLE: start ignored
        start[0] = 1'b1; abort[0] = 1'b1; dir[0] = 1'b1; target[0] = 3'd6;
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        chk("t5b_busy", int'(busy[0]), 0);
        @(negedge clk);
        chk("t5b_out", int'(out[0]), 3);

        // Prescaler 4 with 6 held cycles mid-run
        issue(1, 1'b1, 3'd3);
        repeat (5) @(negedge clk);
        chk("t3_pre_hold", int'(out[1]), 1);
        hold[1] = 1'b1;
        repeat (6) @(negedge clk);
        hold[1] = 1'b0;
        chk("t3_held", int'(out[1]), 1);
        chk("t3_busy_held", int'(busy[1]), 1);
        wait_done(1, 40, k, w);
        chk("t3_cycles", 11 + k, 18);
        chk("t3_out", int'(out[1]), 3);

        // Async reset mid-run at out=5
        issue(0, 1'b1, 3'd2);
        @(negedge clk);
        @(negedge clk);
        chk("t6_out5", int'(out[0]), 5);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_out", int'(out[0]), 0);
        chk("t6_rst_busy", int'(busy[0]), 0);
        chk("t6_rst_ready", int'(ready[0]), 1);
        chk("t6_rst_out4", int'(out[1]), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_out", int'(out[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
